// File: rtl/udp_transmitter.sv
// UDP tx: buffers one payload burst, then emits 8-byte header + payload; first header beat 2 cycles after upper_op_end.
// Output beats are registered and held while snd_rdy_i is low; upper side is stalled (upper_rdy_o low) once a packet is committed.
module udp_transmitter #(
    parameter int DEPTH = 256,
    parameter int AW    = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] src_ip_addr_i,
    input  logic [31:0] dst_ip_addr_i,
    input  logic [15:0] source_port_i,
    input  logic [15:0] dest_port_i,
    input  logic [15:0] payload_len_i,
    input  logic        upper_op_st,
    input  logic        upper_op,
    input  logic        upper_op_end,
    input  logic [31:0] upper_data,
    output logic        upper_rdy_o,
    input  logic        snd_rdy_i,
    output logic        snd_op_st_o,
    output logic        snd_op_o,
    output logic        snd_op_end_o,
    output logic [31:0] snd_data_o,
    output logic [7:0]  prot_type_o,
    output logic [15:0] packet_length_o,
    output logic        drop_o
);

    typedef enum logic [2:0] {IDLE, LOAD, CSUM, HDR0, HDR1, DATA} state_t;

    localparam logic [16:0] MAX_LEN = 17'(4 * DEPTH);
    localparam logic [AW:0] DEPTH_W = (AW + 1)'(DEPTH);
    localparam logic [AW:0] ONE_W   = (AW + 1)'(1);

    state_t      state, state_nxt;
    logic [31:0] src_ip_q, dst_ip_q;
    logic [15:0] sport_q, dport_q, len_q;
    logic [31:0] acc_q;
    logic [AW:0] wcnt_q;
    logic [15:0] csum_q;
    logic [AW:0] rd_ptr_q, rd_ptr_d;
    logic [31:0] rd_dat_q;
    logic [31:0] mem [DEPTH];

    logic [15:0] cur_len;
    logic [AW:0] widx;
    logic [16:0] exp_words, cnt_after;
    logic        last_word, len_bad, wr_en, drop_now;
    logic [31:0] byte_mask, data_m, word_sum;
    logic [31:0] sum_all;
    logic [16:0] fold1;
    logic [15:0] fold2, csum_inv, csum_calc;

    assign upper_rdy_o = (state == IDLE) || (state == LOAD);
    assign prot_type_o = 8'd17;

    // In IDLE the first beat uses the live length/index; afterwards the latched ones.
    always_comb begin
        cur_len   = (state == IDLE) ? payload_len_i : len_q;
        widx      = (state == IDLE) ? '0 : wcnt_q;
        exp_words = ({1'b0, cur_len} + 17'd3) >> 2;
        cnt_after = 17'(widx) + 17'd1;
        last_word = (cnt_after == exp_words);
        byte_mask = 32'hFFFF_FFFF;
        if (last_word) begin
            case (cur_len[1:0])
                2'd1:    byte_mask = 32'hFF00_0000;
                2'd2:    byte_mask = 32'hFFFF_0000;
                2'd3:    byte_mask = 32'hFFFF_FF00;
                default: byte_mask = 32'hFFFF_FFFF;
            endcase
        end
        data_m   = upper_data & byte_mask;
        word_sum = 32'(data_m[31:16]) + 32'(data_m[15:0]);
        len_bad  = (payload_len_i == 16'd0) || ({1'b0, payload_len_i} > MAX_LEN);
    end

    always_comb begin
        sum_all = acc_q
                + 32'(src_ip_q[31:16]) + 32'(src_ip_q[15:0])
                + 32'(dst_ip_q[31:16]) + 32'(dst_ip_q[15:0])
                + 32'h0000_0011 + 32'(packet_length_o)
                + 32'(sport_q) + 32'(dport_q) + 32'(packet_length_o);
        fold1     = {1'b0, sum_all[31:16]} + {1'b0, sum_all[15:0]};
        fold2     = fold1[15:0] + {15'd0, fold1[16]};
        csum_inv  = ~fold2;
        csum_calc = (csum_inv == 16'h0000) ? 16'hFFFF : csum_inv;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        wr_en     = 1'b0;
        drop_now  = 1'b0;
        rd_ptr_d  = rd_ptr_q;
        case (state)
            IDLE: begin
                rd_ptr_d = '0;
                if (upper_op && upper_op_st) begin
                    if (len_bad) begin
                        drop_now = 1'b1;
                    end else begin
                        wr_en = 1'b1;
                        if (!upper_op_end)     state_nxt = LOAD;
                        else if (last_word)    state_nxt = CSUM;
                        else                   drop_now  = 1'b1;
                    end
                end
            end
            LOAD: begin
                if (upper_op) begin
                    if (wcnt_q == DEPTH_W) begin
                        drop_now  = 1'b1;
                        state_nxt = IDLE;
                    end else begin
                        wr_en = 1'b1;
                        if (upper_op_end) begin
                            if (last_word) begin
                                state_nxt = CSUM;
                            end else begin
                                drop_now  = 1'b1;
                                state_nxt = IDLE;
                            end
                        end
                    end
                end
            end
            CSUM: begin
                rd_ptr_d  = '0;
                state_nxt = HDR0;
            end
            HDR0: begin
                if (snd_rdy_i) state_nxt = HDR1;
            end
            HDR1: begin
                if (snd_rdy_i) begin
                    state_nxt = DATA;
                    rd_ptr_d  = rd_ptr_q + ONE_W;
                end
            end
            DATA: begin
                if (snd_rdy_i) begin
                    if (snd_op_end_o) state_nxt = IDLE;
                    else              rd_ptr_d  = rd_ptr_q + ONE_W;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Payload RAM; rd_dat_q always holds mem[rd_ptr_q] so the next beat is ready every cycle.
    always_ff @(posedge clk) begin
        if (wr_en) mem[widx[AW-1:0]] <= data_m;
        rd_dat_q <= mem[rd_ptr_d[AW-1:0]];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            src_ip_q        <= '0;
            dst_ip_q        <= '0;
            sport_q         <= '0;
            dport_q         <= '0;
            len_q           <= '0;
            acc_q           <= '0;
            wcnt_q          <= '0;
            csum_q          <= '0;
            rd_ptr_q        <= '0;
            packet_length_o <= '0;
            drop_o          <= 1'b0;
            snd_op_o        <= 1'b0;
            snd_op_st_o     <= 1'b0;
            snd_op_end_o    <= 1'b0;
            snd_data_o      <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            drop_o   <= drop_now;
            case (state)
                IDLE: begin
                    if (wr_en) begin
                        src_ip_q        <= src_ip_addr_i;
                        dst_ip_q        <= dst_ip_addr_i;
                        sport_q         <= source_port_i;
                        dport_q         <= dest_port_i;
                        len_q           <= payload_len_i;
                        packet_length_o <= payload_len_i + 16'd8;
                        acc_q           <= word_sum;
                        wcnt_q          <= ONE_W;
                    end
                end
                LOAD: begin
                    if (wr_en) begin
                        acc_q  <= acc_q + word_sum;
                        wcnt_q <= wcnt_q + ONE_W;
                    end
                end
                CSUM: begin
                    csum_q       <= csum_calc;
                    snd_op_o     <= 1'b1;
                    snd_op_st_o  <= 1'b1;
                    snd_op_end_o <= 1'b0;
                    snd_data_o   <= {sport_q, dport_q};
                end
                HDR0: begin
                    if (snd_rdy_i) begin
                        snd_op_st_o <= 1'b0;
                        snd_data_o  <= {packet_length_o, csum_q};
                    end
                end
                HDR1: begin
                    if (snd_rdy_i) begin
                        snd_data_o   <= rd_dat_q;
                        snd_op_end_o <= (rd_ptr_q + ONE_W == wcnt_q);
                    end
                end
                DATA: begin
                    if (snd_rdy_i) begin
                        if (snd_op_end_o) begin
                            snd_op_o     <= 1'b0;
                            snd_op_end_o <= 1'b0;
                            snd_data_o   <= '0;
                        end else begin
                            snd_data_o   <= rd_dat_q;
                            snd_op_end_o <= (rd_ptr_q + ONE_W == wcnt_q);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_udp_transmitter.sv
// Directed bench for udp_transmitter: framing, checksum, back-pressure, drops, busy and reset.
module tb_udp_transmitter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] src_ip_addr_i, dst_ip_addr_i;
    logic [15:0] source_port_i, dest_port_i, payload_len_i;
    logic        upper_op_st, upper_op, upper_op_end;
    logic [31:0] upper_data;
    logic        upper_rdy_o, snd_rdy_i;
    logic        snd_op_st_o, snd_op_o, snd_op_end_o;
    logic [31:0] snd_data_o;
    logic [7:0]  prot_type_o;
    logic [15:0] packet_length_o;
    logic        drop_o;

    udp_transmitter dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .src_ip_addr_i   (src_ip_addr_i),
        .dst_ip_addr_i   (dst_ip_addr_i),
        .source_port_i   (source_port_i),
        .dest_port_i     (dest_port_i),
        .payload_len_i   (payload_len_i),
        .upper_op_st     (upper_op_st),
        .upper_op        (upper_op),
        .upper_op_end    (upper_op_end),
        .upper_data      (upper_data),
        .upper_rdy_o     (upper_rdy_o),
        .snd_rdy_i       (snd_rdy_i),
        .snd_op_st_o     (snd_op_st_o),
        .snd_op_o        (snd_op_o),
        .snd_op_end_o    (snd_op_end_o),
        .snd_data_o      (snd_data_o),
        .prot_type_o     (prot_type_o),
        .packet_length_o (packet_length_o),
        .drop_o          (drop_o)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          errors = 0;
    int          op_cnt = 0;
    int          drop_cnt = 0;
    logic [31:0] pay [0:259];
    logic [31:0] rx_dat [0:15];
    logic        rx_st [0:15];
    logic        rx_end [0:15];
    int          rx_n;
    logic [31:0] exp_b [0:2];
    logic [0:5]  bp_pat;
    int          k, o0, d0;

    always @(negedge clk) begin
        if (snd_op_o && snd_rdy_i) op_cnt++;
        if (drop_o) drop_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_pkt(input logic [15:0] len, input int n);
        payload_len_i = len;
        for (int i = 0; i < n; i++) begin
            upper_op     = 1'b1;
            upper_op_st  = (i == 0);
            upper_op_end = (i == n - 1);
            upper_data   = pay[i];
            tick();
        end
        upper_op     = 1'b0;
        upper_op_st  = 1'b0;
        upper_op_end = 1'b0;
        upper_data   = '0;
    endtask

    task automatic recv(input int maxc);
        logic got_end;
        got_end = 1'b0;
        rx_n = 0;
        for (int c = 0; c < maxc && !got_end; c++) begin
            if (snd_op_o && snd_rdy_i && rx_n < 16) begin
                rx_dat[rx_n] = snd_data_o;
                rx_st[rx_n]  = snd_op_st_o;
                rx_end[rx_n] = snd_op_end_o;
                rx_n++;
                if (snd_op_end_o) got_end = 1'b1;
            end
            tick();
        end
        check("recv_end_seen", {31'd0, got_end}, 32'd1);
    endtask

    task automatic basic_pkt(input string tag);
        pay[0] = 32'hDEADBEEF;
        drive_pkt(16'd4, 1);
        check({tag, "_csum_cycle_op"}, snd_op_o, 1'b0);
        tick();
        check({tag, "_lat_op"}, snd_op_o, 1'b1);
        recv(20);
        check({tag, "_n"}, rx_n, 3);
        check({tag, "_w0"}, rx_dat[0], 32'h12345678);
        check({tag, "_w1"}, rx_dat[1], 32'h000C7630);
        check({tag, "_w2"}, rx_dat[2], 32'hDEADBEEF);
        check({tag, "_st"}, {rx_st[0], rx_st[1], rx_st[2]}, 3'b100);
        check({tag, "_end"}, {rx_end[0], rx_end[1], rx_end[2]}, 3'b001);
        check({tag, "_plen"}, packet_length_o, 16'h000C);
        check({tag, "_rdy_after"}, upper_rdy_o, 1'b1);
        check({tag, "_op_after"}, snd_op_o, 1'b0);
        check({tag, "_dat_after"}, snd_data_o, 32'h0);
    endtask

    task automatic drop_case(input string tag, input logic [15:0] len, input int n);
        d0 = drop_cnt;
        o0 = op_cnt;
        drive_pkt(len, n);
        check({tag, "_pulse"}, drop_o, 1'b1);
        for (int i = 0; i < 6; i++) tick();
        check({tag, "_drops"}, drop_cnt - d0, 1);
        check({tag, "_no_tx"}, op_cnt - o0, 0);
        check({tag, "_rdy"}, upper_rdy_o, 1'b1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n         = 1'b0;
        src_ip_addr_i = 32'hC0A8010A;
        dst_ip_addr_i = 32'hC0A80101;
        source_port_i = 16'h1234;
        dest_port_i   = 16'h5678;
        payload_len_i = '0;
        upper_op_st   = 1'b0;
        upper_op      = 1'b0;
        upper_op_end  = 1'b0;
        upper_data    = '0;
        snd_rdy_i     = 1'b1;
        bp_pat        = 6'b100101;
        exp_b[0]      = 32'h12345678;
        exp_b[1]      = 32'h000C7630;
        exp_b[2]      = 32'hDEADBEEF;
        tick();
        tick();
        check("rst_op", snd_op_o, 1'b0);
        check("rst_st", snd_op_st_o, 1'b0);
        check("rst_end", snd_op_end_o, 1'b0);
        check("rst_dat", snd_data_o, 32'h0);
        check("rst_prot", prot_type_o, 8'd17);
        check("rst_plen", packet_length_o, 16'h0);
        check("rst_drop", drop_o, 1'b0);
        check("rst_rdy", upper_rdy_o, 1'b1);
        rst_n = 1'b1;
        tick();

        basic_pkt("basic");

        // odd length: second word keeps only its first byte
        pay[0] = 32'hDEADBEEF;
        pay[1] = 32'hAB112233;
        drive_pkt(16'd5, 2);
        tick();
        recv(20);
        check("odd_n", rx_n, 4);
        check("odd_w0", rx_dat[0], 32'h12345678);
        check("odd_w1", rx_dat[1], 32'h000DCB2D);
        check("odd_w2", rx_dat[2], 32'hDEADBEEF);
        check("odd_w3", rx_dat[3], 32'hAB000000);
        check("odd_end", rx_end[3], 1'b1);
        check("odd_plen", packet_length_o, 16'h000D);

        // back-pressure 1,0,0,1,0,1
        snd_rdy_i = 1'b0;
        pay[0] = 32'hDEADBEEF;
        o0 = op_cnt;
        drive_pkt(16'd4, 1);
        tick();
        k = 0;
        for (int i = 0; i < 20 && k < 3; i++) begin
            if (i < 6) snd_rdy_i = bp_pat[i];
            else       snd_rdy_i = 1'b1;
            check("bp_op", snd_op_o, 1'b1);
            check("bp_dat", snd_data_o, exp_b[k]);
            check("bp_st", snd_op_st_o, (k == 0));
            check("bp_end", snd_op_end_o, (k == 2));
            if (snd_rdy_i) k++;
            tick();
        end
        snd_rdy_i = 1'b1;
        check("bp_beats", k, 3);
        check("bp_xfers", op_cnt - o0, 3);
        check("bp_op_after", snd_op_o, 1'b0);

        // drops
        pay[0] = 32'h01020304;
        drop_case("drop_len0", 16'd0, 1);
        pay[1] = 32'h05060708;
        pay[2] = 32'h090A0B0C;
        drop_case("drop_cnt", 16'd8, 3);
        for (int i = 0; i < 257; i++) pay[i] = 32'(i);
        drop_case("drop_ovf", 16'd1024, 257);

        // checksum folds to FFFF -> transmitted as FFFF
        pay[0] = 32'h13CE0000;
        drive_pkt(16'd4, 1);
        tick();
        recv(20);
        check("zero_n", rx_n, 3);
        check("zero_w1", rx_dat[1], 32'h000CFFFF);
        check("zero_w2", rx_dat[2], 32'h13CE0000);

        // busy: start strobe during HDR1 is ignored
        snd_rdy_i = 1'b0;
        pay[0] = 32'hDEADBEEF;
        drive_pkt(16'd4, 1);
        tick();
        check("busy_hdr0", snd_data_o, 32'h12345678);
        snd_rdy_i = 1'b1;
        tick();
        snd_rdy_i = 1'b0;
        check("busy_rdy", upper_rdy_o, 1'b0);
        pay[0] = 32'h11111111;
        drive_pkt(16'd4, 1);
        check("busy_hold", snd_data_o, 32'h000C7630);
        o0 = op_cnt;
        snd_rdy_i = 1'b1;
        recv(10);
        check("busy_n", rx_n, 2);
        check("busy_w2", rx_dat[1], 32'hDEADBEEF);
        for (int i = 0; i < 6; i++) tick();
        check("busy_no_extra", op_cnt - o0, 2);

        // reset during DATA
        pay[0] = 32'hDEADBEEF;
        pay[1] = 32'h01020304;
        drive_pkt(16'd8, 2);
        tick();
        tick();
        tick();
        check("rstd_data", snd_data_o, 32'hDEADBEEF);
        rst_n = 1'b0;
        #1;
        check("rstd_op", snd_op_o, 1'b0);
        check("rstd_dat", snd_data_o, 32'h0);
        check("rstd_end", snd_op_end_o, 1'b0);
        check("rstd_rdy", upper_rdy_o, 1'b1);
        check("rstd_plen", packet_length_o, 16'h0);
        check("rstd_drop", drop_o, 1'b0);
        tick();
        rst_n = 1'b1;
        tick();
        basic_pkt("after_rst");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
